bpsk_bit_serializer: RTL and testbench



---
 rtl/bpsk_bit_serializer.sv | 82 ++++++++
 tb/tb_bpsk_bit_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bpsk_bit_serializer.sv
// bpsk_bit_serializer: packet-to-bitstream serializer, each bit held WAVELENGTH clocks.
// Define DIFF_ENCODE_EN for differential (DBPSK) encoding of the transmitted bits.
module bpsk_bit_serializer #(
    parameter int   PACKET_SIZE = 64,
    parameter int   WAVELENGTH  = 16,
    parameter logic IDLE_BIT    = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    output logic                   current_bit,
    output logic                   bit_strobe,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = PACKET_SIZE > 1 ? $clog2(PACKET_SIZE) : 1;
    localparam int CW = WAVELENGTH > 1 ? $clog2(WAVELENGTH) : 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_n;
    logic [PACKET_SIZE-1:0] data, data_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic bit_n, strobe_n, boundary, last, ref_bit;
`ifdef DIFF_ENCODE_EN
    // the registered output is the previously sent bit; a start from IDLE uses 0
    assign ref_bit = (state == SEND) && current_bit;
`else
    assign ref_bit = 1'b0;
`endif
    assign busy = state == SEND;
    always_comb begin
        state_n = state;
        data_n = data;
        idx_n = idx;
        cnt_n = cnt;
        bit_n = current_bit;
        strobe_n = 1'b0;
        boundary = (state == SEND) && (cnt == CW'(WAVELENGTH - 1));
        last = boundary && (idx == IW'(PACKET_SIZE - 1));
        packet_ready = (state == IDLE) || last;
        if (packet_valid && packet_ready) begin
            state_n = SEND;
            data_n = packet;
            idx_n = '0;
            cnt_n = '0;
            bit_n = packet[0] ^ ref_bit;
            strobe_n = 1'b1;
        end else if (last) begin
            state_n = IDLE;
            bit_n = IDLE_BIT;
        end else if (boundary) begin
            cnt_n = '0;
            idx_n = idx + 1'b1;
            data_n = data >> 1;
            bit_n = data_n[0] ^ ref_bit;
            strobe_n = 1'b1;
        end else if (state == SEND) begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            data <= '0;
            idx <= '0;
            cnt <= '0;
            current_bit <= IDLE_BIT;
            bit_strobe <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            data <= data_n;
            idx <= idx_n;
            cnt <= cnt_n;
            current_bit <= bit_n;
            bit_strobe <= strobe_n;
            done <= last;
        end
    end
endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// tb_bpsk_bit_serializer: two serializer configurations checked cycle by cycle against a
// timeline model (bit = packet[t / WAVELENGTH]); honours DIFF_ENCODE_EN.
module tb_bpsk_bit_serializer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] pkt_a;
    logic [3:0] pkt_b;
    logic [1:0] valid, ready, cbit, strobe, busy, done;
    int errors = 0;
    int checks = 0;
    int ps[2] = '{8, 4};
    int wl[2] = '{4, 1};
    logic idle[2] = '{1'b0, 1'b1};
    logic m_busy[2], m_bit[2], m_done[2];
    logic [7:0] m_pkt[2];
    int m_t[2];
    int done_seen[2];
    bit diff;

    always #5 clock = ~clock;

    bpsk_bit_serializer #(.PACKET_SIZE(8), .WAVELENGTH(4), .IDLE_BIT(1'b0)) dut_a (
        .clock(clock), .reset(reset), .packet(pkt_a), .packet_valid(valid[0]),
        .packet_ready(ready[0]), .current_bit(cbit[0]), .bit_strobe(strobe[0]),
        .busy(busy[0]), .done(done[0])
    );
    bpsk_bit_serializer #(.PACKET_SIZE(4), .WAVELENGTH(1), .IDLE_BIT(1'b1)) dut_b (
        .clock(clock), .reset(reset), .packet(pkt_b), .packet_valid(valid[1]),
        .packet_ready(ready[1]), .current_bit(cbit[1]), .bit_strobe(strobe[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] p[2];
        logic hs[2], last[2];
        p[0] = pkt_a;
        p[1] = {4'b0, pkt_b};
        for (int d = 0; d < 2; d++) begin
            last[d] = m_busy[d] && m_t[d] == ps[d] * wl[d] - 1;
            hs[d] = valid[d] && (!m_busy[d] || last[d]);
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
                m_t[d] = 0;
            end else begin
                m_done[d] = last[d];
                if (hs[d]) begin
                    m_bit[d] = p[d][0] ^ (diff && m_busy[d] && m_bit[d]);
                    m_busy[d] = 1'b1;
                    m_pkt[d] = p[d];
                    m_t[d] = 0;
                end else if (last[d]) begin
                    m_busy[d] = 1'b0;
                end else if (m_busy[d]) begin
                    m_t[d]++;
                    if (m_t[d] % wl[d] == 0)
                        m_bit[d] = m_pkt[d][m_t[d] / wl[d]] ^ (diff && m_bit[d]);
                end
            end
            if (done[d] === 1'b1) done_seen[d]++;
            chk($sformatf("bit%0d", d), cbit[d], m_busy[d] ? m_bit[d] : idle[d]);
            chk($sformatf("strobe%0d", d), strobe[d], m_busy[d] && m_t[d] % wl[d] == 0);
            chk($sformatf("busy%0d", d), busy[d], m_busy[d]);
            chk($sformatf("done%0d", d), done[d], m_done[d]);
            chk($sformatf("ready%0d", d), ready[d], !m_busy[d] || m_t[d] == ps[d] * wl[d] - 1);
        end
    endtask

    initial begin
        int n;
`ifdef DIFF_ENCODE_EN
        diff = 1'b1;
`else
        diff = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_bit[d] = 1'b0;
            m_done[d] = 1'b0;
            m_pkt[d] = '0;
            m_t[d] = 0;
            done_seen[d] = 0;
        end
        valid = '0;
        pkt_a = '0;
        pkt_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        // single packets, inputs scrambled after the handshake
        pkt_a = 8'b1011_0010;
        pkt_b = 4'b0110;
        valid = 2'b11;
        done_seen = '{0, 0};
        tick();
        valid = '0;
        repeat (40) begin
            pkt_a = 8'($urandom);
            pkt_b = 4'($urandom);
            tick();
        end
        chk_int("single_done_a", done_seen[0], 1);
        chk_int("single_done_b", done_seen[1], 1);
        // back-to-back: 8'hFF offered throughout the first packet
        pkt_a = 8'($urandom);
        valid[0] = 1'b1;
        done_seen[0] = 0;
        tick();
        pkt_a = 8'hFF;
        n = 0;
        while (ready[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_ready", ready[0], 1'b1);
        chk_int("b2b_wait", n, 31);
        tick();
        valid[0] = 1'b0;
        repeat (40) tick();
        chk_int("b2b_done_a", done_seen[0], 2);
        // reset on cycle 10 of a packet
        pkt_a = 8'($urandom);
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        done_seen[0] = 0;
        repeat (40) tick();
        chk_int("reset_no_done", done_seen[0], 0);
        // random traffic with occasional resets
        repeat (600) begin
            pkt_a = 8'($urandom);
            pkt_b = 4'($urandom);
            valid[0] = $urandom_range(0, 3) != 0;
            valid[1] = $urandom_range(0, 2) == 0;
            reset = $urandom_range(0, 150) == 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
